// File: rtl/alu_result_tx_pkg.sv
// Shared definitions for the ALU-result UART transmitter: FSM encoding,
// default baud divider and 8N1 frame constants.
package alu_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 100 MHz system clock, 115200 baud
  localparam int DEF_CLKS_PER_BIT = 868;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/alu_result_tx_if.sv
// Request/status bundle between an ALU result producer and the UART sender.
interface alu_result_tx_if #(
  parameter int N = 16
) ();

  logic                start;
  logic signed [N-1:0] data;
  logic                tx;
  logic                busy;
  logic                done;

  modport master (
    output start,
    output data,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/alu_result_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period. Held at zero while disabled so every frame
// sequence starts with a full-length first bit.
module baud_tick_gen
  import alu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("baud_tick_gen: CLKS_PER_BIT must be >= 2");
  end

  logic [CW-1:0] cnt;

  // Free-running bit-period counter, cleared whenever the transmitter idles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/alu_result_tx.sv
// Serialises an N-bit signed ALU result over a UART line as N/8 back-to-back
// 8N1 frames, least-significant byte first. All outputs come straight from
// flops, so start/data never reach tx combinationally.
module alu_result_tx
  import alu_uart_pkg::*;
#(
  parameter int N            = 16,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_result_tx_if.slave  bus
);

  localparam int NBYTES = N / 8;
  localparam int BCW    = $clog2(NBYTES) + 1;
  localparam int BITW   = $clog2(DATA_BITS);

  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [BITW-1:0] LAST_BIT  = BITW'(DATA_BITS - 1);

  if ((N < 8) || ((N % 8) != 0)) begin : g_bad_n
    $error("alu_result_tx: N must be a multiple of 8 and >= 8");
  end

  state_t              state;
  logic signed [N-1:0] shreg;
  logic [BITW-1:0]     bit_cnt;
  logic [BCW-1:0]      byte_cnt;
  logic                tx_r;
  logic                busy_r;
  logic                done_r;
  logic                tick;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state != IDLE),
    .tick   (tick)
  );

  // Frame sequencer: captures the result on accept and walks START/DATA/STOP
  // once per byte; tx, busy and done are all registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_r     <= STOP_LVL;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          tx_r <= STOP_LVL;
          if (bus.start && !busy_r) begin
            shreg    <= bus.data;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            busy_r   <= 1'b1;
            tx_r     <= START_LVL;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            bit_cnt <= '0;
            tx_r    <= shreg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            // Shift on every bit so the next byte's LSB lands in bit 0
            shreg <= shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              tx_r  <= STOP_LVL;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BITW'(1);
              tx_r    <= shreg[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              state    <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
              tx_r     <= START_LVL;
              state    <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx   = tx_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: a 16-bit and a 32-bit instance at 4 clocks/bit.
// Line monitors decode every 8N1 frame and compare bytes against a queue of
// expected bytes pushed when each transfer is launched.
module tb_alu_result_tx;
  import alu_uart_pkg::*;

  localparam int C  = 4;
  localparam int FL = 10 * C;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_result_tx_if #(.N(16)) a_if ();
  alu_result_tx_if #(.N(32)) b_if ();

  alu_result_tx #(.N(16), .CLKS_PER_BIT(C)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  alu_result_tx #(.N(32), .CLKS_PER_BIT(C)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_a   = 0;
  int done_b   = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Bit-exact frame decode: every bit must hold for all C samples
  task automatic decode(input logic [FL-1:0] s, output logic [7:0] b, output int bad);
    bad = 0;
    b   = '0;
    for (int k = 0; k < 10; k++)
      for (int j = 1; j < C; j++)
        if (s[k*C+j] !== s[k*C]) bad++;
    if (s[0] !== START_LVL) bad++;
    if (s[9*C] !== STOP_LVL) bad++;
    for (int k = 0; k < 8; k++) b[k] = s[(k+1)*C];
  endtask

  // Line monitor for the 16-bit instance
  initial begin : mon_a
    logic [FL-1:0] s;
    int            c;
    int            bad;
    logic [7:0]    b;
    logic [7:0]    e;
    c = 0;
    s = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c = 0;
      end else begin
        if (a_if.done === 1'b1) begin
          done_a++;
          chk("done_while_busy_a", int'(a_if.busy), 0);
        end
        if (c != 0 || a_if.tx === 1'b0) begin
          s[c] = a_if.tx;
          c++;
          if (c == FL) begin
            c = 0;
            decode(s, b, bad);
            chk("frame_shape_a", bad, 0);
            chk("rx_expected_a", int'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
              e = q_a.pop_front();
              chk("rx_byte_a", int'(b), int'(e));
            end
          end
        end
      end
    end
  end

  // Line monitor for the 32-bit instance
  initial begin : mon_b
    logic [FL-1:0] s;
    int            c;
    int            bad;
    logic [7:0]    b;
    logic [7:0]    e;
    c = 0;
    s = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c = 0;
      end else begin
        if (b_if.done === 1'b1) begin
          done_b++;
          chk("done_while_busy_b", int'(b_if.busy), 0);
        end
        if (c != 0 || b_if.tx === 1'b0) begin
          s[c] = b_if.tx;
          c++;
          if (c == FL) begin
            c = 0;
            decode(s, b, bad);
            chk("frame_shape_b", bad, 0);
            chk("rx_expected_b", int'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
              e = q_b.pop_front();
              chk("rx_byte_b", int'(b), int'(e));
            end
          end
        end
      end
    end
  end

  task automatic start_a(input logic [15:0] d);
    @(negedge clk);
    a_if.data  = d;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    chk("busy_after_accept_a", int'(a_if.busy), 1);
  endtask

  // Counts busy samples from the current one; optionally pulses start with
  // data pd at busy sample pulse_at to show it is ignored
  task automatic wait_idle_a(input int pulse_at, input logic [15:0] pd, output int cyc);
    int guard;
    cyc   = 0;
    guard = 0;
    while (a_if.busy === 1'b1 && guard < 1000) begin
      cyc++;
      guard++;
      if (pulse_at != 0 && cyc == pulse_at) begin
        a_if.data  = pd;
        a_if.start = 1'b1;
      end else begin
        a_if.start = 1'b0;
      end
      @(negedge clk);
    end
    a_if.start = 1'b0;
    chk("busy_timeout_a", int'(guard < 1000), 1);
  endtask

  initial begin : main
    vec_t vecs[6];
    int   cyc;
    int   d0;
    int   dev;
    int   busy_n;
    int   gap;
    int   falls;
    int   guard;
    logic prev;

    vecs[0] = '{16'hA53C, 8'h3C, 8'hA5};
    vecs[1] = '{16'h0001, 8'h01, 8'h00};
    vecs[2] = '{16'h8000, 8'h00, 8'h80};
    vecs[3] = '{16'h7FFF, 8'hFF, 8'h7F};
    vecs[4] = '{16'h00FF, 8'hFF, 8'h00};
    vecs[5] = '{16'h5AC3, 8'hC3, 8'h5A};

    a_if.start = 1'b0;
    a_if.data  = '0;
    b_if.start = 1'b0;
    b_if.data  = '0;
    rst_n      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_a",   int'(a_if.tx),   1);
    chk("rst_busy_a", int'(a_if.busy), 0);
    chk("rst_done_a", int'(a_if.done), 0);
    chk("rst_tx_b",   int'(b_if.tx),   1);
    rst_n = 1'b1;
    dev = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_if.tx !== 1'b1 || a_if.busy !== 1'b0 || a_if.done !== 1'b0) dev++;
    end
    chk("idle_after_reset_a", dev, 0);

    // Table-driven single transfers
    for (int i = 0; i < 6; i++) begin
      q_a.push_back(vecs[i].b0);
      q_a.push_back(vecs[i].b1);
      d0 = done_a;
      start_a(vecs[i].data);
      wait_idle_a(0, 16'h0000, cyc);
      chk("busy_cycles_a", cyc, 2 * 10 * C);
      repeat (3) @(negedge clk);
      chk("done_pulses_a", done_a - d0, 1);
      chk("queue_drained_a", q_a.size(), 0);
      repeat (4) @(negedge clk);
    end

    // Start and new data during a transfer are ignored
    q_a.push_back(8'h01);
    q_a.push_back(8'h00);
    d0 = done_a;
    start_a(16'h0001);
    wait_idle_a(30, 16'hFFFF, cyc);
    chk("busy_cycles_ignore_a", cyc, 2 * 10 * C);
    repeat (3 * FL) @(negedge clk);
    chk("done_pulses_ignore_a", done_a - d0, 1);
    chk("queue_drained_ignore_a", q_a.size(), 0);

    // Back-to-back with start held high
    q_a.push_back(8'h00);
    q_a.push_back(8'h80);
    q_a.push_back(8'hFF);
    q_a.push_back(8'h7F);
    d0 = done_a;
    @(negedge clk);
    a_if.data  = 16'h8000;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.data = 16'h7FFF;
    busy_n = 0;
    gap    = 0;
    falls  = 0;
    guard  = 0;
    prev   = 1'b1;
    while (falls < 2 && guard < 1000) begin
      guard++;
      if (a_if.busy === 1'b1) begin
        busy_n++;
        if (falls == 1) a_if.start = 1'b0;
        prev = 1'b1;
      end else begin
        if (prev) falls++;
        if (falls == 1) gap++;
        prev = 1'b0;
      end
      if (falls < 2) @(negedge clk);
    end
    a_if.start = 1'b0;
    chk("b2b_timeout_a", int'(guard < 1000), 1);
    chk("b2b_busy_cycles_a", busy_n, 4 * 10 * C);
    chk("b2b_gap_cycles_a", gap, 1);
    repeat (3) @(negedge clk);
    chk("b2b_done_pulses_a", done_a - d0, 2);
    chk("b2b_queue_drained_a", q_a.size(), 0);

    // Reset in the middle of a frame
    repeat (4) @(negedge clk);
    d0 = done_a;
    start_a(16'h0000);
    repeat (20) @(negedge clk);
    chk("midframe_tx_low_a",   int'(a_if.tx),   0);
    chk("midframe_busy_a",     int'(a_if.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_a",   int'(a_if.tx),   1);
    chk("async_rst_busy_a", int'(a_if.busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FL) @(negedge clk);
    chk("no_done_after_abort_a", done_a - d0, 0);
    chk("idle_tx_after_abort_a", int'(a_if.tx), 1);
    q_a.push_back(8'h3C);
    q_a.push_back(8'hA5);
    d0 = done_a;
    start_a(16'hA53C);
    wait_idle_a(0, 16'h0000, cyc);
    chk("busy_cycles_post_rst_a", cyc, 2 * 10 * C);
    repeat (3) @(negedge clk);
    chk("done_pulses_post_rst_a", done_a - d0, 1);
    chk("queue_drained_post_rst_a", q_a.size(), 0);

    // 32-bit width variant
    q_b.push_back(8'h78);
    q_b.push_back(8'h56);
    q_b.push_back(8'h34);
    q_b.push_back(8'h12);
    d0 = done_b;
    @(negedge clk);
    b_if.data  = 32'h12345678;
    b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    b_if.data  = 32'hFFFFFFFF;
    cyc   = 0;
    guard = 0;
    while (b_if.busy === 1'b1 && guard < 1000) begin
      cyc++;
      guard++;
      @(negedge clk);
    end
    chk("busy_timeout_b", int'(guard < 1000), 1);
    chk("busy_cycles_b", cyc, 4 * 10 * C);
    repeat (3) @(negedge clk);
    chk("done_pulses_b", done_b - d0, 1);
    chk("queue_drained_b", q_b.size(), 0);
    chk("idle_tx_b", int'(b_if.tx), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
